// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction memory read port, processor-side instruction
// handshake and the redirect/halt controls.
interface instr_fetch_if;
    logic       enable;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halted;

    modport master (
        input  enable, mem_rdata, instr_ready, redirect, redirect_pc,
        output mem_rd, mem_addr, instr, instr_pc, instr_valid, halted
    );

    modport slave (
        output enable, mem_rdata, instr_ready, redirect, redirect_pc,
        input  mem_rd, mem_addr, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction prefetch unit: issues sequential reads, queues the returned words
// in a small shift FIFO whose entry 0 drives the processor outputs directly.
module instr_fetch #(
    parameter int         DEPTH    = 2,
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] HALT_OP  = 8'hFF
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next, wr_idx;
    logic [CW:0]   occ;
    logic [7:0]    fetch_pc, rd_addr;
    logic          rd_pending, valid_q;
    logic          pop, push, halt_now, flush, rd_en;
    logic [7:0]    buf_data [DEPTH];
    logic [7:0]    buf_pc   [DEPTH];

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = valid_q && bus.instr_ready;
        halt_now   = (state == RUN) && pop && (buf_data[0] == HALT_OP) && !bus.redirect;
        flush      = bus.redirect || halt_now;
        push       = (state == RUN) && rd_pending && !flush;
        // Credit the entry leaving this cycle so a full-rate stream never stalls.
        occ        = (CW+1)'(cnt) + (CW+1)'(rd_pending) - (CW+1)'(pop);
        rd_en      = !rst && (state == RUN) && bus.enable && !bus.redirect
                     && (occ < (CW+1)'(DEPTH));
        wr_idx     = cnt - CW'(pop);
        cnt_next   = flush ? '0 : cnt + CW'(push) - CW'(pop);
        case (state)
            RUN:    if (halt_now)     state_next = HALTED;
            HALTED: if (bus.redirect) state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            valid_q    <= 1'b0;
            fetch_pc   <= RESET_PC;
            rd_pending <= 1'b0;
            rd_addr    <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            valid_q    <= (cnt_next != '0);
            rd_pending <= rd_en && !halt_now;
            rd_addr    <= fetch_pc;
            if (bus.redirect)
                fetch_pc <= bus.redirect_pc;
            else if (rd_en)
                fetch_pc <= fetch_pc + 8'd1;
        end
    end

    // NOTE: the storage is reset because entry 0 is the instr/instr_pc output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (pop) begin
                    buf_data[i] <= buf_data[i+1];
                    buf_pc[i]   <= buf_pc[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_idx == CW'(i)) begin
                    buf_data[i] <= bus.mem_rdata;
                    buf_pc[i]   <= rd_addr;
                end
            end
        end
    end

    assign bus.mem_rd      = rd_en;
    assign bus.mem_addr    = rd_en ? fetch_pc : 8'h00;
    assign bus.instr       = buf_data[0];
    assign bus.instr_pc    = buf_pc[0];
    assign bus.instr_valid = valid_q;
    assign bus.halted      = (state == HALTED);
endmodule
